// File: rtl/spike_weight_streamer.sv
// spike_weight_streamer
//   Per timestep, walks the latched presynaptic spike vector in ascending
//   index order. For each set bit it reads that input's weight from a
//   synchronous weight RAM and emits a one-cycle spike/weight pulse toward
//   the downstream accumulator. A done pulse closes the timestep.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-low
//   start        begin a timestep (sampled only when idle)
//   spike_vec    presynaptic spikes, captured on the accepted start
//   wmem_en      weight-RAM read enable
//   wmem_addr    weight-RAM read address (presynaptic index)
//   wmem_rdata   RAM read data, valid one cycle after wmem_en
//   out_spike    one-cycle spike pulse
//   out_weight   weight paired with out_spike (0 otherwise)
//   busy         timestep in progress
//   done         one-cycle end-of-timestep pulse
//   spike_count  spikes emitted in the current or last timestep
module spike_weight_streamer #(
  parameter int N_IN = 16,
  parameter int W    = 16,
  localparam int AW  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N_IN-1:0] spike_vec,
  output logic            wmem_en,
  output logic [AW-1:0]   wmem_addr,
  input  logic [W-1:0]    wmem_rdata,
  output logic            out_spike,
  output logic [W-1:0]    out_weight,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     spike_count
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N_IN-1:0] mask;
  logic [N_IN-1:0] mask_low;
  logic [AW-1:0]   low_idx;
  logic            mask_any;

  assign mask_any = |mask;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = N_IN; i > 0; i--) begin
      if (mask[i-1]) low_idx = AW'(i - 1);
    end
  end

  assign mask_low = N_IN'(1) << low_idx;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    state_nxt = mask_any ? WAIT : DONE;
      WAIT:    state_nxt = SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign wmem_en   = (state == SCAN) && mask_any;
  assign wmem_addr = low_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask        <= '0;
      out_spike   <= 1'b0;
      out_weight  <= '0;
      spike_count <= '0;
    end else begin
      out_spike  <= 1'b0;
      out_weight <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            mask        <= spike_vec;
            spike_count <= '0;
          end
        end
        SCAN: begin
          if (mask_any) mask <= mask & ~mask_low;
        end
        WAIT: begin
          out_spike   <= 1'b1;
          out_weight  <= wmem_rdata;
          spike_count <= spike_count + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
